// File: rtl/vdp_pixel_blend_pkg.sv
// Shared VDP constants, types and blend helpers for the pixel-output stage.
package vdp_pixel_blend_pkg;

    localparam int unsigned PAL_DEPTH = 256;
    localparam int unsigned PAL_AW    = 8;
    localparam int unsigned PAL_DW    = 16;
    localparam int unsigned LAYER_W   = 5;
    localparam int unsigned CH_W      = 4;
    localparam int unsigned WEIGHT_W  = 5;
    localparam int unsigned SUM_W     = 9;

    // ARGB4444 field positions
    localparam int unsigned ARGB_A_LSB = 12;
    localparam int unsigned ARGB_R_LSB = 8;
    localparam int unsigned ARGB_G_LSB = 4;
    localparam int unsigned ARGB_B_LSB = 0;

    localparam logic [LAYER_W-1:0] LAYER_NONE    = 5'b00000;
    localparam logic [LAYER_W-1:0] LAYER_SCROLL0 = 5'b00001;
    localparam logic [LAYER_W-1:0] LAYER_SCROLL1 = 5'b00010;
    localparam logic [LAYER_W-1:0] LAYER_SCROLL2 = 5'b00100;
    localparam logic [LAYER_W-1:0] LAYER_SCROLL3 = 5'b01000;
    localparam logic [LAYER_W-1:0] LAYER_SPRITE  = 5'b10000;
    localparam logic [LAYER_W-1:0] LAYER_ALL     = LAYER_SCROLL0 | LAYER_SCROLL1 |
                                                   LAYER_SCROLL2 | LAYER_SCROLL3 |
                                                   LAYER_SPRITE;

    typedef logic [PAL_DW-1:0] argb_t;

    typedef struct packed {
        logic               valid;
        logic [LAYER_W-1:0] layer;
        logic [LAYER_W-1:0] masked_layer;
        logic               blend_enable;
        argb_t              background;
    } ctrl_t;

    function automatic logic [CH_W-1:0] argb_field(input argb_t c, input int unsigned lsb);
        return CH_W'(c >> lsb);
    endfunction

    // Fully opaque alpha maps to weight 16 so a=15 yields the masked colour exactly.
    function automatic logic [WEIGHT_W-1:0] alpha_weight(input logic [CH_W-1:0] a);
        return (a == 4'hF) ? WEIGHT_W'(16) : WEIGHT_W'(a);
    endfunction

    function automatic logic [CH_W-1:0] blend_channel(input logic [CH_W-1:0]     m,
                                                      input logic [CH_W-1:0]     p,
                                                      input logic [WEIGHT_W-1:0] w);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(m) * SUM_W'(w) + SUM_W'(p) * (SUM_W'(16) - SUM_W'(w));
        return CH_W'(sum >> CH_W);
    endfunction

endpackage

// File: rtl/vdp_pixel_blend_if.sv
// Pixel-in / pixel-out / palette-write bundle of the VDP blend stage.
interface vdp_pixel_blend_if;
    import vdp_pixel_blend_pkg::*;

    logic               pixel_valid_in;
    logic [PAL_AW-1:0]  prioritized_pixel;
    logic [LAYER_W-1:0] prioritized_layer;
    logic [PAL_AW-1:0]  prioritized_masked_pixel;
    logic [LAYER_W-1:0] prioritized_masked_layer;
    logic               blend_enable;
    argb_t              background_color;
    logic               palette_write_en;
    logic [PAL_AW-1:0]  palette_write_address;
    argb_t              palette_write_data;
    logic               pixel_valid_out;
    logic [CH_W-1:0]    r;
    logic [CH_W-1:0]    g;
    logic [CH_W-1:0]    b;

    modport master (
        output pixel_valid_in, prioritized_pixel, prioritized_layer,
               prioritized_masked_pixel, prioritized_masked_layer,
               blend_enable, background_color,
               palette_write_en, palette_write_address, palette_write_data,
        input  pixel_valid_out, r, g, b
    );

    modport slave (
        input  pixel_valid_in, prioritized_pixel, prioritized_layer,
               prioritized_masked_pixel, prioritized_masked_layer,
               blend_enable, background_color,
               palette_write_en, palette_write_address, palette_write_data,
        output pixel_valid_out, r, g, b
    );
endinterface

// File: rtl/vdp_blend_palette.sv
// 256x16 palette: one write port, two mirrored synchronous read ports with an output register.
module vdp_blend_palette
    import vdp_pixel_blend_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [PAL_AW-1:0] waddr,
    input  argb_t             wdata,
    input  logic [PAL_AW-1:0] raddr_a,
    input  logic [PAL_AW-1:0] raddr_b,
    output argb_t             rdata_a,
    output argb_t             rdata_b
);

    argb_t mem_a [PAL_DEPTH];
    argb_t mem_b [PAL_DEPTH];
    argb_t rd_a_q;
    argb_t rd_b_q;

    // Read-first: a same-cycle write is seen only by reads issued afterwards.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_a[waddr] <= wdata;
            mem_b[waddr] <= wdata;
        end
        rd_a_q  <= mem_a[raddr_a];
        rd_b_q  <= mem_b[raddr_b];
        rdata_a <= rd_a_q;
        rdata_b <= rd_b_q;
    end

endmodule

// File: rtl/vdp_pixel_blend.sv
// VDP pixel-output stage: palette lookup of primary/masked pixels, alpha blend, RGB444 out.
module vdp_pixel_blend
    import vdp_pixel_blend_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    vdp_pixel_blend_if.slave bus
);

    ctrl_t              s1_ctrl;
    ctrl_t              s2_ctrl;
    argb_t              pal_primary;
    argb_t              pal_masked;
    logic               s3_valid;
    logic               s3_do_blend;
    argb_t              s3_primary;
    argb_t              s3_masked;
    argb_t              primary_sel_c;
    logic               do_blend_c;
    logic [WEIGHT_W-1:0] w_c;
    logic [CH_W-1:0]    r_c;
    logic [CH_W-1:0]    g_c;
    logic [CH_W-1:0]    b_c;
    logic               valid_q;
    logic [CH_W-1:0]    r_q;
    logic [CH_W-1:0]    g_q;
    logic [CH_W-1:0]    b_q;

    vdp_blend_palette u_palette (
        .clk     (clk),
        .we      (bus.palette_write_en),
        .waddr   (bus.palette_write_address),
        .wdata   (bus.palette_write_data),
        .raddr_a (bus.prioritized_pixel),
        .raddr_b (bus.prioritized_masked_pixel),
        .rdata_a (pal_primary),
        .rdata_b (pal_masked)
    );

    // Control travels two cycles to line up with the palette read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_ctrl <= '0;
            s2_ctrl <= '0;
        end else begin
            s1_ctrl.valid        <= bus.pixel_valid_in;
            s1_ctrl.layer        <= bus.prioritized_layer;
            s1_ctrl.masked_layer <= bus.prioritized_masked_layer;
            s1_ctrl.blend_enable <= bus.blend_enable;
            s1_ctrl.background   <= bus.background_color;
            s2_ctrl              <= s1_ctrl;
        end
    end

    always_comb begin
        primary_sel_c = pal_primary;
        do_blend_c    = s2_ctrl.blend_enable &&
                        ((s2_ctrl.masked_layer & LAYER_ALL) != LAYER_NONE);
        if ((s2_ctrl.layer & LAYER_ALL) == LAYER_NONE) begin
            primary_sel_c = s2_ctrl.background;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_valid    <= 1'b0;
            s3_do_blend <= 1'b0;
            s3_primary  <= '0;
            s3_masked   <= '0;
        end else begin
            s3_valid    <= s2_ctrl.valid;
            s3_do_blend <= do_blend_c;
            s3_primary  <= primary_sel_c;
            s3_masked   <= pal_masked;
        end
    end

    // Primary alpha is ignored; masked alpha sets the blend weight.
    always_comb begin
        w_c = alpha_weight(argb_field(s3_masked, ARGB_A_LSB));
        r_c = argb_field(s3_primary, ARGB_R_LSB);
        g_c = argb_field(s3_primary, ARGB_G_LSB);
        b_c = argb_field(s3_primary, ARGB_B_LSB);
        if (s3_do_blend) begin
            r_c = blend_channel(argb_field(s3_masked, ARGB_R_LSB), argb_field(s3_primary, ARGB_R_LSB), w_c);
            g_c = blend_channel(argb_field(s3_masked, ARGB_G_LSB), argb_field(s3_primary, ARGB_G_LSB), w_c);
            b_c = blend_channel(argb_field(s3_masked, ARGB_B_LSB), argb_field(s3_primary, ARGB_B_LSB), w_c);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= s3_valid;
            r_q     <= r_c;
            g_q     <= g_c;
            b_q     <= b_c;
        end
    end

    assign bus.pixel_valid_out = valid_q;
    assign bus.r               = r_q;
    assign bus.g               = g_q;
    assign bus.b               = b_q;

endmodule
